onehot_decoder128: RTL

Pipelined 7-bit index to 128-bit one-hot decoder with valid/ready handshaking on both sides. It is the inverse of the 128-to-7 one-hot encoder already in the wrapper datapath. It regenerates select/enable vectors from compact indices coming off the encoder side or from a control FSM. A 2-stage pipeline keeps the 128-wide fan-out off the input timing path.

---
 rtl/onehot_dec_pkg.sv | 13 +
 rtl/onehot_dec_n.sv | 14 +
 rtl/onehot_decoder128.sv | 96 +++++++++
 3 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared constants and types for the 7-bit index to 128-bit one-hot decoder.
// The index splits into a 3-bit group field and a 4-bit low field.
package onehot_dec_pkg;

    localparam int IDX_W = 7;
    localparam int GRP_W = 3;
    localparam int LOW_W = 4;
    localparam int OUT_W = 128;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [OUT_W-1:0] onehot_t;

endpackage

// File: rtl/onehot_dec_n.sv
// Generic combinational N to 2**N one-hot decoder.
module onehot_dec_n #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   dec
);

    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/onehot_decoder128.sv
// Two-stage pipelined 7-bit index to 128-bit one-hot decoder.
// Stage 1 holds the partial group/low decodes, stage 2 the final AND array.
module onehot_decoder128 #(
    parameter int IDX_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_index,
    input  logic                 in_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IDX_W-1:0]  out_onehot,
    output logic [IDX_W-1:0]     out_index
);

    import onehot_dec_pkg::*;

    if (IDX_W != 7) begin : g_bad_width
        $error("onehot_decoder128: only IDX_W = 7 is supported");
    end

    localparam int GRP_N = 2**GRP_W;
    localparam int LOW_N = 2**LOW_W;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    idx_t             s1_index;
    logic             s1_en;
    logic [GRP_N-1:0] s1_grp;
    logic [LOW_N-1:0] s1_low;
    logic [GRP_N-1:0] grp_dec;
    logic [LOW_N-1:0] low_dec;
    onehot_t          and_vec;

    // Both stages can move together, so in_ready is combinational in out_ready.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    onehot_dec_n #(.N(GRP_W)) u_grp_dec (
        .sel (in_index[IDX_W-1:LOW_W]),
        .dec (grp_dec)
    );

    onehot_dec_n #(.N(LOW_W)) u_low_dec (
        .sel (in_index[LOW_W-1:0]),
        .dec (low_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_en    <= 1'b0;
            s1_grp   <= '0;
            s1_low   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_index <= in_index;
                s1_en    <= in_en;
                s1_grp   <= grp_dec;
                s1_low   <= low_dec;
            end
        end
    end

    always_comb begin
        and_vec = '0;
        for (int g = 0; g < GRP_N; g++) begin
            for (int l = 0; l < LOW_N; l++) begin
                and_vec[g*LOW_N+l] = s1_grp[g] & s1_low[l] & s1_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_onehot <= '0;
            out_index  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_onehot <= and_vec;
                out_index  <= s1_index;
            end
        end
    end

endmodule
